// File: rtl/irq_ctrl.sv
// Machine-mode trap sequencer: takes exceptions, interrupts and MRET on a valid
// instruction and walks the pipeline through save / redirect.
module irq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ext_irq_i,
  input  logic        sft_irq_i,
  input  logic        tmr_irq_i,
  input  logic        meie_i,
  input  logic        msie_i,
  input  logic        mtie_i,
  input  logic        glb_irq_i,
  input  logic        exp_ecall_i,
  input  logic        exp_ebreak_i,
  input  logic        exp_illegal_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_pc_i,
  input  logic        mret_i,
  input  logic [31:0] irq_pc_i,
  input  logic [31:0] mepc_i,
  output logic        hold_pipe_o,
  output logic        flush_o,
  output logic        jump_ena_o,
  output logic [31:0] jump_addr_o,
  output logic        trap_wen_o,
  output logic [31:0] epc_o,
  output logic [31:0] cause_o,
  output logic        irq_src_o,
  output logic        exp_src_o,
  output logic        mret_ena_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SAVE = 2'd1;
  localparam logic [1:0] JUMP = 2'd2;
  localparam logic [1:0] MRET = 2'd3;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CAUSE_EBREAK  = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL   = 32'h0000_000B;
  localparam logic [31:0] CAUSE_EXT     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SFT     = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TMR     = 32'h8000_0007;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        in_idle;
  logic        take_exp;
  logic        take_irq;
  logic        take_mret;
  logic        take_trap;
  logic [31:0] exp_cause;
  logic [31:0] irq_cause;

  assign in_idle   = (state == IDLE);
  assign take_exp  = instr_valid_i & (exp_ecall_i | exp_ebreak_i | exp_illegal_i);
  assign take_irq  = instr_valid_i & glb_irq_i &
                     ((ext_irq_i & meie_i) | (sft_irq_i & msie_i) | (tmr_irq_i & mtie_i));
  assign take_mret = instr_valid_i & mret_i;
  assign take_trap = take_exp | take_irq;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    exp_cause = CAUSE_ECALL;
    if (exp_illegal_i)     exp_cause = CAUSE_ILLEGAL;
    else if (exp_ebreak_i) exp_cause = CAUSE_EBREAK;
  end

  always_comb begin
    irq_cause = CAUSE_TMR;
    if (ext_irq_i & meie_i)      irq_cause = CAUSE_EXT;
    else if (sft_irq_i & msie_i) irq_cause = CAUSE_SFT;
  end

  // Exceptions beat interrupts, and both beat MRET on the same instruction.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take_trap)      state_nxt = SAVE;
        else if (take_mret) state_nxt = MRET;
      end
      SAVE:    state_nxt = JUMP;
      JUMP:    state_nxt = IDLE;
      MRET:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the trap context registers are reset so epc/cause read as zero
  // while reset is held, not just after the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_o     <= '0;
      cause_o   <= '0;
      irq_src_o <= 1'b0;
      exp_src_o <= 1'b0;
    end else if (in_idle && take_trap) begin
      epc_o     <= instr_pc_i;
      cause_o   <= take_exp ? exp_cause : irq_cause;
      exp_src_o <= take_exp;
      irq_src_o <= ~take_exp;
    end else if (state == JUMP) begin
      irq_src_o <= 1'b0;
      exp_src_o <= 1'b0;
    end
  end

  // The stall in the accepting cycle is combinational; gating with rst_n keeps
  // it low while reset is asserted even if a request is present.
  always_comb begin
    hold_pipe_o = 1'b0;
    if (rst_n) hold_pipe_o = in_idle ? (take_trap | take_mret) : 1'b1;
  end

  assign trap_wen_o = (state == SAVE);
  assign jump_ena_o = (state == JUMP) | (state == MRET);
  assign flush_o    = jump_ena_o;
  assign mret_ena_o = (state == MRET);

  always_comb begin
    jump_addr_o = '0;
    case (state)
      JUMP:    jump_addr_o = irq_pc_i;
      MRET:    jump_addr_o = mepc_i;
      default: jump_addr_o = '0;
    endcase
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have ports, in this order: clk  in  1  clock (sole clock); rst_n  in  1  reset, asynchronous assert, active-low.
REQ-002 SHALL have: ext_irq_i, sft_irq_i, tmr_irq_i  in  1 each  level interrupt requests (external, software, timer).
REQ-003 SHALL have: meie_i, msie_i, mtie_i, glb_irq_i  in  1 each  per-source and global enables from the CSR file.
REQ-004 SHALL have: exp_ecall_i, exp_ebreak_i, exp_illegal_i  in  1 each  exception flags for the instruction at instr_pc_i.
REQ-005 SHALL have: instr_valid_i  in  1  instr_pc_i holds a real, uncommitted instruction; instr_pc_i  in  32  its PC; mret_i  in  1  that instruction is MRET.
REQ-006 SHALL have: irq_pc_i  in  32  trap entry address (mtvec); mepc_i  in  32  return address.
REQ-007 SHALL have: hold_pipe_o  out  1  stall; flush_o  out  1  kill younger instructions; jump_ena_o  out  1; jump_addr_o  out  32.
REQ-008 SHALL have: trap_wen_o  out  1  write mepc/mcause; epc_o  out  32; cause_o  out  32; irq_src_o  out  1; exp_src_o  out  1; mret_ena_o  out  1.

Function
REQ-009 SHALL implement FSM states IDLE, SAVE, JUMP, MRET; it SHALL leave IDLE only when instr_valid_i=1.
REQ-010 take_exp = instr_valid_i & (exp_ecall_i | exp_ebreak_i | exp_illegal_i).
REQ-011 take_irq = instr_valid_i & glb_irq_i & ((ext_irq_i&meie_i) | (sft_irq_i&msie_i) | (tmr_irq_i&mtie_i)).
REQ-012 Priority in IDLE: take_exp > take_irq > mret_i; the winner is sampled in cycle N.
REQ-013 Exception cause SHALL be: illegal 0x00000002 > ebreak 0x00000003 > ecall 0x0000000B (highest first when several are set).
REQ-014 Interrupt cause SHALL be: external 0x8000000B > software 0x80000003 > timer 0x80000007.
REQ-015 On trap in cycle N: hold_pipe_o=1 combinationally in N; at the end of N latch epc_o=instr_pc_i, cause_o, irq_src_o/exp_src_o (exactly one set); next state SAVE.
REQ-016 SAVE (N+1): trap_wen_o=1, hold_pipe_o=1; next state JUMP.
REQ-017 JUMP (N+2): jump_ena_o=1, flush_o=1, hold_pipe_o=1, jump_addr_o=irq_pc_i; next state IDLE; irq_src_o/exp_src_o SHALL clear on leaving JUMP.
REQ-018 On mret_i winning in cycle N: hold_pipe_o=1 in N; next state MRET.
REQ-019 MRET (N+1): jump_ena_o=1, flush_o=1, mret_ena_o=1, hold_pipe_o=1, jump_addr_o=mepc_i; next state IDLE.
REQ-020 Requests, exceptions and mret_i arriving outside IDLE SHALL be ignored; still-asserted level interrupts are re-evaluated on return to IDLE.
REQ-021 trap_wen_o, jump_ena_o, flush_o and mret_ena_o SHALL each be single-cycle pulses per event; jump_addr_o=0 outside JUMP/MRET.
REQ-022 A new trap SHALL be accepted in the first IDLE cycle after JUMP or MRET (back-to-back allowed).

Reset
REQ-023 rst_n=0 SHALL force state IDLE and all outputs 0 (epc_o=0, cause_o=0) immediately, without waiting for a clk edge, including mid-trap.
REQ-024 After rst_n deasserts, the first trap SHALL be accepted no earlier than the first rising edge of clk.

Verification
REQ-025 tmr_irq_i=1, mtie_i=1, glb_irq_i=1, instr_valid_i=1, instr_pc_i=0x80000010, irq_pc_i=0x80000100 -> trap_wen_o at N+1 with epc_o=0x80000010, cause_o=0x80000007; jump_ena_o at N+2 to 0x80000100.
REQ-026 ext_irq_i=sft_irq_i=1 plus exp_illegal_i=1, all enabled -> cause_o=0x00000002, exp_src_o=1, irq_src_o=0.
REQ-027 glb_irq_i=0 with all sources and per-source enables set -> hold_pipe_o stays 0, no trap; then glb_irq_i=1 -> trap with cause 0x8000000B.
REQ-028 mret_i=1, mepc_i=0x80000014 -> at N+1 jump_ena_o=1, mret_ena_o=1, jump_addr_o=0x80000014; a pending enabled sft_irq_i in the same cycle N instead yields cause 0x80000003 with epc_o equal to the MRET PC.
REQ-029 rst_n pulsed low during SAVE -> all outputs 0 asynchronously; no jump_ena_o pulse follows.
REQ-030 Two exceptions on consecutive valid instructions -> two complete IDLE-SAVE-JUMP sequences with no cycle lost between them; exp_ecall_i asserted during SAVE is ignored.
